frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/game_pkg.sv | 33 +++
 rtl/draw_watchdog.sv | 47 ++++
 rtl/frame_sequencer.sv | 143 ++++++++++++++
 tb/tb_frame_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game frame sequencer and datapath debug logic.
//   state_e                  : encoded sequencer states (0..8, in frame order)
//   STATE_W                  : width of the encoded state
//   NUM_STATES               : number of states / one-hot strobes
//   TIMEOUT_CYCLES_DEFAULT   : default draw-state watchdog limit (cycles)
//   is_draw_state()          : true for the three draw states
// ---------------------------------------------------------------------------
package game_pkg;

  localparam int STATE_W    = 4;
  localparam int NUM_STATES = 9;

  localparam logic [19:0] TIMEOUT_CYCLES_DEFAULT = 20'd262143;

  typedef enum logic [STATE_W-1:0] {
    S_INIT          = 4'd0,
    S_DRAW_MAP      = 4'd1,
    S_DRAW_LINK     = 4'd2,
    S_DRAW_ENEMIES  = 4'd3,
    S_IDLE          = 4'd4,
    S_GEN_MOVE      = 4'd5,
    S_CHECK_COLLIDE = 4'd6,
    S_APPLY_LINK    = 4'd7,
    S_MOVE_ENEMIES  = 4'd8
  } state_e;

  function automatic logic is_draw_state(input state_e s);
    return (s == S_DRAW_MAP) || (s == S_DRAW_LINK) || (s == S_DRAW_ENEMIES);
  endfunction

endpackage

// File: rtl/draw_watchdog.sv
// ---------------------------------------------------------------------------
// draw_watchdog
// Counts cycles spent in the current draw state and flags expiry once the
// state has been occupied for LIMIT cycles (expired is high during the
// LIMIT-th cycle, so the sequencer leaves on that cycle's edge).
// Only instantiated when DRAW_WATCHDOG_EN is defined.
// Ports:
//   clock    in  system clock
//   reset    in  synchronous active-high reset, clears the count
//   clear    in  restart the count (asserted the cycle before a state entry)
//   enable   in  count this cycle (current state is a draw state)
//   expired  out limit reached in this cycle
// ---------------------------------------------------------------------------
module draw_watchdog #(
  parameter logic [19:0] LIMIT = 20'd262143
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [19:0] count_q, count_d;

  // count_q holds the number of cycles already completed in the state, so
  // the LIMIT-th cycle sees LIMIT-1.
  assign expired = enable && (count_q == (LIMIT - 20'd1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 20'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// ---------------------------------------------------------------------------
// frame_sequencer
// Moore FSM that sequences one game frame: draw map, draw link, draw
// enemies, wait for the frame tick, then the four single-cycle game-logic
// steps, and back to drawing. Every strobe is a register loaded from the
// next-state decode, so exactly one strobe is high and it matches state_dbg.
//
// Optional feature: define DRAW_WATCHDOG_EN to add a per-draw-state
// watchdog (draw_watchdog) that forces the FSM onward after TIMEOUT_CYCLES
// and raises a sticky timeout_err. Without it the draw states wait forever
// and timeout_err is tied low.
//
// Ports:
//   clock, reset                      clock and synchronous active-high reset
//   pause                             hold in IDLE while high
//   idle_done                         frame tick (level)
//   draw_map_done / draw_link_done /
//   draw_enemies_done                 draw completion flags (level)
//   init .. draw_enemies              registered one-hot state strobes
//   frame_count                       completed frames, wraps at 16 bits
//   state_dbg                         encoded current state (game_pkg::state_e)
//   timeout_err                       sticky watchdog error
// ---------------------------------------------------------------------------
module frame_sequencer
  import game_pkg::*;
#(
  parameter logic [19:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         pause,
  input  logic         idle_done,
  input  logic         draw_map_done,
  input  logic         draw_link_done,
  input  logic         draw_enemies_done,
  output logic         init,
  output logic         idle,
  output logic         gen_move,
  output logic         check_collide,
  output logic         apply_act_link,
  output logic         move_enemies,
  output logic         draw_map,
  output logic         draw_link,
  output logic         draw_enemies,
  output logic [15:0]  frame_count,
  output logic [STATE_W-1:0] state_dbg,
  output logic         timeout_err
);

  state_e                state_q, state_d;
  logic                  armed_q, armed_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic [NUM_STATES-1:0] strobe_q, strobe_d;
  logic                  wd_expired;

  // ---------------------------------------------------------------------
  // Optional draw-state watchdog
  // ---------------------------------------------------------------------
`ifdef DRAW_WATCHDOG_EN
  logic timeout_err_q;

  draw_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_draw_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_d != state_q),
    .enable  (is_draw_state(state_q)),
    .expired (wd_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      timeout_err_q <= 1'b0;
    end else if (wd_expired) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign wd_expired            = 1'b0;
  assign timeout_err           = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    frame_count_d = frame_count_q;
    unique case (state_q)
      S_INIT:         state_d = S_DRAW_MAP;
      // armed_q is low on the first cycle of a draw state, so a done
      // left high from the previous frame cannot be taken as fresh.
      S_DRAW_MAP:     if ((armed_q && draw_map_done) || wd_expired)
                        state_d = S_DRAW_LINK;
      S_DRAW_LINK:    if ((armed_q && draw_link_done) || wd_expired)
                        state_d = S_DRAW_ENEMIES;
      S_DRAW_ENEMIES: if ((armed_q && draw_enemies_done) || wd_expired) begin
                        state_d       = S_IDLE;
                        frame_count_d = frame_count_q + 16'd1;
                      end
      // A tick seen while paused is dropped, not queued.
      S_IDLE:         if (idle_done && !pause) state_d = S_GEN_MOVE;
      S_GEN_MOVE:      state_d = S_CHECK_COLLIDE;
      S_CHECK_COLLIDE: state_d = S_APPLY_LINK;
      S_APPLY_LINK:    state_d = S_MOVE_ENEMIES;
      S_MOVE_ENEMIES:  state_d = S_DRAW_MAP;
      default:         state_d = S_INIT;
    endcase

    // Disarmed on every entry, armed after one cycle of residency.
    armed_d  = (state_d == state_q);
    strobe_d = NUM_STATES'(1) << state_d;
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_INIT;
      armed_q       <= 1'b0;
      frame_count_q <= '0;
      strobe_q      <= NUM_STATES'(1);
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      frame_count_q <= frame_count_d;
      strobe_q      <= strobe_d;
    end
  end

  assign {move_enemies, apply_act_link, check_collide, gen_move,
          idle, draw_enemies, draw_link, draw_map, init} = strobe_q;

  assign frame_count = frame_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_sequencer
// Directed bench for frame_sequencer. Strobes are gathered into a vector
// whose bit i is the strobe of state i, so expected one-hot values read as
// 9'h001 (init), 9'h002 (draw_map), ... 9'h100 (move_enemies).
// Build with DRAW_WATCHDOG_EN to exercise the watchdog (TIMEOUT_CYCLES=16).
// ---------------------------------------------------------------------------
module tb_frame_sequencer;

  logic        clock;
  logic        reset;
  logic        pause;
  logic        idle_done;
  logic        draw_map_done;
  logic        draw_link_done;
  logic        draw_enemies_done;
  logic        init, idle, gen_move, check_collide, apply_act_link;
  logic        move_enemies, draw_map, draw_link, draw_enemies;
  logic [15:0] frame_count;
  logic [3:0]  state_dbg;
  logic        timeout_err;
  logic [8:0]  strobes;

  int total;
  int bad;

  frame_sequencer #(
    .TIMEOUT_CYCLES (20'd16)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .pause             (pause),
    .idle_done         (idle_done),
    .draw_map_done     (draw_map_done),
    .draw_link_done    (draw_link_done),
    .draw_enemies_done (draw_enemies_done),
    .init              (init),
    .idle              (idle),
    .gen_move          (gen_move),
    .check_collide     (check_collide),
    .apply_act_link    (apply_act_link),
    .move_enemies      (move_enemies),
    .draw_map          (draw_map),
    .draw_link         (draw_link),
    .draw_enemies      (draw_enemies),
    .frame_count       (frame_count),
    .state_dbg         (state_dbg),
    .timeout_err       (timeout_err)
  );

  assign strobes = {move_enemies, apply_act_link, check_collide, gen_move,
                    idle, draw_enemies, draw_link, draw_map, init};

  // ---- clock / reset --------------------------------------------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL time_limit: sim time=%0t exceeded bound", $time);
    $fatal(1, "time limit");
  end

  // ---- driver tasks ---------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // From the first cycle of S_DRAW_MAP, walk all three draws to S_IDLE.
  task automatic draw_all();
    tick(); draw_map_done = 1'b1;     tick(); draw_map_done = 1'b0;
    tick(); draw_link_done = 1'b1;    tick(); draw_link_done = 1'b0;
    tick(); draw_enemies_done = 1'b1; tick(); draw_enemies_done = 1'b0;
  endtask

  // From S_IDLE, pulse the tick and run the four logic steps to S_DRAW_MAP.
  task automatic run_logic();
    idle_done = 1'b1; tick(); idle_done = 1'b0;
    tick(); tick(); tick(); tick();
  endtask

  // ---- scenarios --------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; pause = 1'b0; idle_done = 1'b0;
    draw_map_done = 1'b0; draw_link_done = 1'b0; draw_enemies_done = 1'b0;
    tick(); tick();
    total++; if (strobes !== 9'h001) begin bad++; $display("FAIL rst_strobes: got=%h want=%h", strobes, 9'h001); end
    total++; if (state_dbg !== 4'd0) begin bad++; $display("FAIL rst_state: got=%0d want=0", state_dbg); end
    total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL rst_count: got=%h want=0", frame_count); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_tmo: got=%b want=0", timeout_err); end
    reset = 1'b0;
    // The cycle after release is still S_INIT.
    total++; if (init !== 1'b1) begin bad++; $display("FAIL rel_init: got=%b want=1", init); end
    tick();
    total++; if (strobes !== 9'h002) begin bad++; $display("FAIL rel_map: got=%h want=%h", strobes, 9'h002); end
    total++; if (state_dbg !== 4'd1) begin bad++; $display("FAIL rel_state: got=%0d want=1", state_dbg); end
    total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL rel_count: got=%h want=0", frame_count); end
  endtask

  task automatic test_arm_cycle();
    // Arm cycle of S_DRAW_MAP: done must be ignored.
    draw_map_done = 1'b1; tick(); draw_map_done = 1'b0;
    total++; if (state_dbg !== 4'd1) begin bad++; $display("FAIL arm_ignore: got=%0d want=1", state_dbg); end
    tick();
    total++; if (state_dbg !== 4'd1) begin bad++; $display("FAIL arm_wait: got=%0d want=1", state_dbg); end
    draw_map_done = 1'b1; tick(); draw_map_done = 1'b0;
    total++; if (strobes !== 9'h004) begin bad++; $display("FAIL arm_link: got=%h want=%h", strobes, 9'h004); end
    total++; if (state_dbg !== 4'd2) begin bad++; $display("FAIL arm_link_state: got=%0d want=2", state_dbg); end
  endtask

  task automatic test_frame();
    // In S_DRAW_LINK: non-matching dones cause no state change.
    draw_map_done = 1'b1; draw_enemies_done = 1'b1; idle_done = 1'b1;
    tick(); tick();
    total++; if (state_dbg !== 4'd2) begin bad++; $display("FAIL wrong_done: got=%0d want=2", state_dbg); end
    draw_map_done = 1'b0; idle_done = 1'b0;
    draw_link_done = 1'b1; tick(); draw_link_done = 1'b0;
    total++; if (strobes !== 9'h008) begin bad++; $display("FAIL to_enemies: got=%h want=%h", strobes, 9'h008); end
    // draw_enemies_done still high: stale on the arm cycle.
    tick();
    total++; if (state_dbg !== 4'd3) begin bad++; $display("FAIL stale_done: got=%0d want=3", state_dbg); end
    tick(); draw_enemies_done = 1'b0;
    total++; if (strobes !== 9'h010) begin bad++; $display("FAIL to_idle: got=%h want=%h", strobes, 9'h010); end
    total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL count1: got=%0d want=1", frame_count); end
    tick(); tick();
    total++; if (state_dbg !== 4'd4) begin bad++; $display("FAIL idle_wait: got=%0d want=4", state_dbg); end
    idle_done = 1'b1; tick(); idle_done = 1'b0;
    total++; if (strobes !== 9'h020) begin bad++; $display("FAIL gen_move: got=%h want=%h", strobes, 9'h020); end
    tick();
    total++; if (strobes !== 9'h040) begin bad++; $display("FAIL check_collide: got=%h want=%h", strobes, 9'h040); end
    tick();
    total++; if (strobes !== 9'h080) begin bad++; $display("FAIL apply_link: got=%h want=%h", strobes, 9'h080); end
    tick();
    total++; if (strobes !== 9'h100) begin bad++; $display("FAIL move_enemies: got=%h want=%h", strobes, 9'h100); end
    tick();
    total++; if (strobes !== 9'h002) begin bad++; $display("FAIL loop_map: got=%h want=%h", strobes, 9'h002); end
    total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL loop_count: got=%0d want=1", frame_count); end
  endtask

  task automatic test_pause();
    draw_all();
    total++; if (frame_count !== 16'd2) begin bad++; $display("FAIL count2: got=%0d want=2", frame_count); end
    pause = 1'b1; idle_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (strobes !== 9'h010) begin bad++; $display("FAIL pause_hold[%0d]: got=%h want=%h", i, strobes, 9'h010); end
    end
    // Tick seen during pause is not remembered.
    pause = 1'b0; idle_done = 1'b0; tick();
    total++; if (state_dbg !== 4'd4) begin bad++; $display("FAIL pause_no_mem: got=%0d want=4", state_dbg); end
    idle_done = 1'b1; tick(); idle_done = 1'b0;
    total++; if (strobes !== 9'h020) begin bad++; $display("FAIL unpause_gen: got=%h want=%h", strobes, 9'h020); end
    tick(); tick(); tick(); tick();
    total++; if (state_dbg !== 4'd1) begin bad++; $display("FAIL pause_loop: got=%0d want=1", state_dbg); end
  endtask

  task automatic test_wrap();
    force dut.frame_count_q = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    #1;
    total++; if (frame_count !== 16'hFFFF) begin bad++; $display("FAIL forced_count: got=%h want=ffff", frame_count); end
    draw_all();
    total++; if (frame_count !== 16'h0000) begin bad++; $display("FAIL wrap_count: got=%h want=0000", frame_count); end
    total++; if (state_dbg !== 4'd4) begin bad++; $display("FAIL wrap_state: got=%0d want=4", state_dbg); end
  endtask

  task automatic test_reset_mid();
    run_logic();
    tick(); draw_map_done = 1'b1; tick(); draw_map_done = 1'b0;
    total++; if (state_dbg !== 4'd2) begin bad++; $display("FAIL mid_link: got=%0d want=2", state_dbg); end
    tick();
    reset = 1'b1; tick();
    total++; if (strobes !== 9'h001) begin bad++; $display("FAIL mid_rst_strobes: got=%h want=%h", strobes, 9'h001); end
    total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL mid_rst_count: got=%h want=0", frame_count); end
    reset = 1'b0; tick();
    total++; if (state_dbg !== 4'd1) begin bad++; $display("FAIL mid_rel: got=%0d want=1", state_dbg); end
  endtask

  task automatic test_watchdog();
    // Starts on the first cycle of S_DRAW_MAP.
    tick(); draw_map_done = 1'b1; tick(); draw_map_done = 1'b0;
`ifdef DRAW_WATCHDOG_EN
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL wd_pre: got=%b want=0", timeout_err); end
    for (int i = 0; i < 16; i++) begin
      total++; if (strobes !== 9'h004) begin bad++; $display("FAIL wd_hold[%0d]: got=%h want=%h", i, strobes, 9'h004); end
      tick();
    end
    total++; if (strobes !== 9'h008) begin bad++; $display("FAIL wd_advance: got=%h want=%h", strobes, 9'h008); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL wd_err: got=%b want=1", timeout_err); end
    tick(); draw_enemies_done = 1'b1; tick(); draw_enemies_done = 1'b0;
    total++; if (state_dbg !== 4'd4) begin bad++; $display("FAIL wd_idle: got=%0d want=4", state_dbg); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL wd_sticky: got=%b want=1", timeout_err); end
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL wd_clear: got=%b want=0", timeout_err); end
`else
    for (int i = 0; i < 40; i++) tick();
    total++; if (state_dbg !== 4'd2) begin bad++; $display("FAIL no_wd_wait: got=%0d want=2", state_dbg); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL no_wd_err: got=%b want=0", timeout_err); end
`endif
  endtask

  // ---- sequence and report -----------------------------------------------
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_arm_cycle();
    test_frame();
    test_pause();
    test_wrap();
    test_reset_mid();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
